// File: rtl/ising_logic_pkg.sv
// Shared types for the Ising core logic: requester tags and the J-memory
// wide-port request/response structs used by the read bridge.
package ising_logic_pkg;

  typedef enum logic {
    PORT_LOAD = 1'b0,
    PORT_CMPT = 1'b1
  } port_tag_e;

  localparam int unsigned JAddrWidth = 10;
  localparam int unsigned JDataWidth = 256;
  localparam int unsigned JStrbWidth = JDataWidth / 8;

  typedef struct packed {
    logic [JAddrWidth-1:0] addr;
    logic                  write;
    logic [JDataWidth-1:0] data;
    logic [JStrbWidth-1:0] strb;
  } j_mem_q_t;

  typedef struct packed {
    j_mem_q_t q;
    logic     q_user;
    logic     q_valid;
  } j_mem_req_t;

  typedef struct packed {
    logic [JDataWidth-1:0] data;
    logic                  valid;
  } j_mem_p_t;

  typedef struct packed {
    logic     q_ready;
    j_mem_p_t p;
  } j_mem_rsp_t;

  function automatic port_tag_e mode_to_tag(input logic mode);
    if (mode) begin
      return PORT_CMPT;
    end else begin
      return PORT_LOAD;
    end
  endfunction

endpackage

// File: rtl/ising_j_rd_bridge_tag_fifo.sv
// In-order FIFO of requester tags for reads accepted by the J-memory port.
// The bridge never pushes when full nor pops when empty, so no status flags are kept.
module ising_j_rd_bridge_tag_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PtrWidth'(1);
    end
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push_i) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (pop_i) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
    end
  end

  assign data_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/ising_j_rd_bridge.sv
// Read bridge from the load and compute requesters onto the J-memory wide port:
// one pending request slot, bounded outstanding reads, in-order tag routing.
module ising_j_rd_bridge
  import ising_logic_pkg::*;
#(
  parameter int unsigned AddrWidth      = JAddrWidth,
  parameter int unsigned DataWidth      = JDataWidth,
  parameter int unsigned MaxOutstanding = 2,
  parameter type         mem_req_t      = j_mem_req_t,
  parameter type         mem_rsp_t      = j_mem_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mode_i,
  output logic                 mode_o,
  input  logic                 load_ren_i,
  input  logic [AddrWidth-1:0] load_raddr_i,
  output logic [DataWidth-1:0] load_rdata_o,
  output logic                 load_rvalid_o,
  input  logic                 cmpt_ren_i,
  input  logic [AddrWidth-1:0] cmpt_raddr_i,
  output logic [DataWidth-1:0] cmpt_rdata_o,
  output logic                 cmpt_rvalid_o,
  output mem_req_t             mem_req_o,
  input  mem_rsp_t             mem_rsp_i,
  output logic                 busy_o,
  input  logic                 clr_err_i,
  output logic [1:0]           err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  port_tag_e             r_mode;
  logic                  r_pend_valid;
  logic [AddrWidth-1:0]  r_pend_addr;
  logic [CntWidth-1:0]   r_cnt;
  logic [1:0]            r_err;
  logic [DataWidth-1:0]  r_load_rdata;
  logic                  r_load_rvalid;
  logic [DataWidth-1:0]  r_cmpt_rdata;
  logic                  r_cmpt_rvalid;

  logic                  w_act_ren;
  logic [AddrWidth-1:0]  w_act_addr;
  logic                  w_inact_ren;
  logic                  w_any_ren;
  logic                  w_busy;
  logic                  w_q_valid;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_set_ovf;
  logic [0:0]            w_push_tag;
  logic [0:0]            w_pop_tag;

  always_comb begin
    if (r_mode == PORT_CMPT) begin
      w_act_ren   = cmpt_ren_i;
      w_act_addr  = cmpt_raddr_i;
      w_inact_ren = load_ren_i;
    end else begin
      w_act_ren   = load_ren_i;
      w_act_addr  = load_raddr_i;
      w_inact_ren = cmpt_ren_i;
    end
  end

  assign w_any_ren  = load_ren_i || cmpt_ren_i;
  assign w_busy     = r_pend_valid || (r_cnt != '0);
  assign w_q_valid  = r_pend_valid && (r_cnt < CntWidth'(MaxOutstanding));
  assign w_hs       = w_q_valid && mem_rsp_i.q_ready;
  // Responses arriving with nothing outstanding (e.g. after reset) are stale.
  assign w_pop      = mem_rsp_i.p.valid && (r_cnt != '0);
  assign w_set_ovf  = w_act_ren && r_pend_valid && !w_hs;
  assign w_push_tag = r_mode;

  always_comb begin
    mem_req_o         = '0;
    mem_req_o.q.addr  = r_pend_addr;
    mem_req_o.q.strb  = '1;
    mem_req_o.q_valid = w_q_valid;
  end

  ising_j_rd_bridge_tag_fifo #(
    .DATA_WIDTH (1),
    .DEPTH      (MaxOutstanding)
  ) i_tag_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (w_hs),
    .data_i (w_push_tag),
    .pop_i  (w_pop),
    .data_o (w_pop_tag)
  );

  // Mode only switches when fully idle so every in-flight tag matches its port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode <= PORT_LOAD;
    end else if (!w_busy && !w_any_ren) begin
      r_mode <= mode_to_tag(mode_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (w_act_ren && (!r_pend_valid || w_hs)) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= w_act_addr;
    end else if (w_hs) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + CntWidth'(1);
        2'b01:   r_cnt <= r_cnt - CntWidth'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A set wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 2'b00;
    end else begin
      r_err <= {w_inact_ren, w_set_ovf} | (r_err & ~{2{clr_err_i}});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_load_rdata  <= '0;
      r_load_rvalid <= 1'b0;
      r_cmpt_rdata  <= '0;
      r_cmpt_rvalid <= 1'b0;
    end else begin
      r_load_rvalid <= 1'b0;
      r_cmpt_rvalid <= 1'b0;
      if (w_pop) begin
        if (port_tag_e'(w_pop_tag) == PORT_CMPT) begin
          r_cmpt_rdata  <= mem_rsp_i.p.data;
          r_cmpt_rvalid <= 1'b1;
        end else begin
          r_load_rdata  <= mem_rsp_i.p.data;
          r_load_rvalid <= 1'b1;
        end
      end
    end
  end

  assign mode_o        = r_mode;
  assign busy_o        = w_busy;
  assign err_o         = r_err;
  assign load_rdata_o  = r_load_rdata;
  assign load_rvalid_o = r_load_rvalid;
  assign cmpt_rdata_o  = r_cmpt_rdata;
  assign cmpt_rvalid_o = r_cmpt_rvalid;

endmodule

// File: tb/tb_ising_j_rd_bridge.sv
// Self-checking bench for ising_j_rd_bridge: directed vector table, hand-written
// corner sequences and random traffic, all scored against a queue-based model.
module tb_ising_j_rd_bridge;
  import ising_logic_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mode_i, mode_o, lren, cren, clr, q_ready, inj_pv, busy;
  logic lrv, crv;
  logic [9:0] laddr, caddr;
  logic [255:0] ldata, cdata;
  logic [1:0] err;
  j_mem_req_t mem_req;
  j_mem_rsp_t mem_rsp;
  logic mem_pv = 1'b0;
  logic [255:0] mem_pd = '0;

  ising_j_rd_bridge #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode_i), .mode_o(mode_o),
    .load_ren_i(lren), .load_raddr_i(laddr), .load_rdata_o(ldata), .load_rvalid_o(lrv),
    .cmpt_ren_i(cren), .cmpt_raddr_i(caddr), .cmpt_rdata_o(cdata), .cmpt_rvalid_o(crv),
    .mem_req_o(mem_req), .mem_rsp_i(mem_rsp), .busy_o(busy), .clr_err_i(clr), .err_o(err)
  );

  always_comb begin
    mem_rsp.q_ready = q_ready;
    mem_rsp.p.data  = mem_pd;
    mem_rsp.p.valid = mem_pv | inj_pv;
  end

  function automatic logic [255:0] mdata(input logic [9:0] a);
    logic [31:0] w;
    if (a == 10'h005) return {32{8'hA5}};
    w = 32'h5EED_0000 ^ ({22'd0, a} * 32'h9E37_79B1);
    return {8{w}};
  endfunction

  // Memory: fixed latency, in order, data derived from the address.
  typedef struct { int unsigned due; logic [9:0] addr; } mq_t;
  mq_t mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req.q_valid && q_ready) mq.push_back('{due: cyc + lat - 1, addr: mem_req.q.addr});
    mem_pv <= 1'b0;
    if (mq.size() != 0 && mq[0].due == cyc) begin
      mem_pv <= 1'b1;
      mem_pd <= mdata(mq[0].addr);
      mq.pop_front();
    end
  end

  // Reference model
  typedef struct { bit port; logic [9:0] addr; } tag_t;
  tag_t m_tags[$];
  bit m_mode, m_pv, e_lv, e_cv;
  logic [9:0] m_pa;
  logic [1:0] m_err;
  logic [255:0] e_ld, e_cd;
  int n_checks = 0;
  int n_fail = 0;

  task automatic model_step();
    bit ra, ri, qv, hs, pv, bsy;
    logic [9:0] aa;
    tag_t t;
    if (!rst_n) begin
      m_tags.delete(); m_mode = 0; m_pv = 0; m_pa = '0; m_err = 2'b00;
      e_lv = 0; e_cv = 0; e_ld = '0; e_cd = '0;
      return;
    end
    ra  = m_mode ? cren : lren;
    aa  = m_mode ? caddr : laddr;
    ri  = m_mode ? lren : cren;
    bsy = m_pv || (m_tags.size() != 0);
    qv  = m_pv && (m_tags.size() < MAXO);
    hs  = qv && q_ready;
    pv  = (mem_pv || inj_pv) && (m_tags.size() != 0);
    e_lv = 0; e_cv = 0;
    if (pv) begin
      t = m_tags.pop_front();
      if (t.port) begin e_cv = 1; e_cd = mdata(t.addr); end
      else begin e_lv = 1; e_ld = mdata(t.addr); end
    end
    if (hs) m_tags.push_back('{port: m_mode, addr: m_pa});
    m_err = {ri, ra && m_pv && !hs} | (m_err & ~{2{clr}});
    if (ra && (!m_pv || hs)) begin m_pv = 1; m_pa = aa; end
    else if (hs) m_pv = 0;
    if (!bsy && !lren && !cren) m_mode = mode_i;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit qv;
    qv = m_pv && (m_tags.size() < MAXO);
    chk("mode_o", int'(mode_o), int'(m_mode));
    chk("err_o", int'(err), int'(m_err));
    chk("busy_o", int'(busy), int'(m_pv || (m_tags.size() != 0)));
    chk("q_valid", int'(mem_req.q_valid), int'(qv));
    if (qv) chk("q_addr", int'(mem_req.q.addr), int'(m_pa));
    chk("load_rvalid", int'(lrv), int'(e_lv));
    chk("cmpt_rvalid", int'(crv), int'(e_cv));
    chkd("load_rdata", ldata, e_ld);
    chkd("cmpt_rdata", cdata, e_cd);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit lr, input bit cr, input logic [9:0] la, input logic [9:0] ca,
                        input bit md, input bit rd, input bit cl);
    lren = lr; cren = cr; laddr = la; caddr = ca; mode_i = md; q_ready = rd; clr = cl;
  endtask

  function automatic int inflight_now();
    return mq.size() + (mem_pv ? 1 : 0);
  endfunction

  typedef struct {
    bit lren; bit cren; logic [9:0] addr; bit mode; bit rdy; bit clr;
    bit e_qv; logic [9:0] e_qa; bit e_mode; logic [1:0] e_err; bit e_lrv; bit e_crv;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t v(input bit lr, input bit cr, input logic [9:0] a, input bit md,
                             input bit rd, input bit cl, input bit qv, input logic [9:0] qa,
                             input bit em, input logic [1:0] ee, input bit lv, input bit cv);
    vec_t r;
    r.lren = lr; r.cren = cr; r.addr = a; r.mode = md; r.rdy = rd; r.clr = cl;
    r.e_qv = qv; r.e_qa = qa; r.e_mode = em; r.e_err = ee; r.e_lrv = lv; r.e_crv = cv;
    return r;
  endfunction

  initial begin
    int lrv_cnt, rv_cnt, sw_at;
    bit rmode;
    // basic read, latency 1
    tbl[0]  = v(1'b1, 1'b0, 10'h005, 1'b0, 1'b1, 1'b0, 1'b1, 10'h005, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[2]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[3]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    // backpressure with a dropped second request
    tbl[4]  = v(1'b1, 1'b0, 10'h010, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[5]  = v(1'b1, 1'b0, 10'h011, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[6]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[7]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[8]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[9]  = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[10] = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b01, 1'b1, 1'b0);
    tbl[11] = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    // clear racing a new overflow, then an inactive-port request
    tbl[12] = v(1'b1, 1'b0, 10'h020, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[13] = v(1'b1, 1'b0, 10'h021, 1'b0, 1'b0, 1'b1, 1'b1, 10'h020, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 1'b1, 10'h030, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 2'b11, 1'b0, 1'b0);
    tbl[15] = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[16] = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b1, 1'b0);
    // idle mode switch and a compute read
    tbl[17] = v(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 2'b00, 1'b0, 1'b0);
    tbl[18] = v(1'b0, 1'b1, 10'h030, 1'b1, 1'b1, 1'b0, 1'b1, 10'h030, 1'b1, 2'b00, 1'b0, 1'b0);
    tbl[19] = v(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 2'b00, 1'b0, 1'b0);
    tbl[20] = v(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 2'b00, 1'b0, 1'b1);
    tbl[21] = v(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0);

    rst_n = 1'b0; inj_pv = 1'b0; lat = 1;
    set_in(1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1, 1'b0);
    step(); step();
    rst_n = 1'b1;
    chk("q_strb", int'(&mem_req.q.strb), 1);
    chk("q_write_user_data", int'({mem_req.q.write, mem_req.q_user, |mem_req.q.data}), 0);

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].lren, tbl[i].cren, tbl[i].addr, tbl[i].addr, tbl[i].mode, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_q_valid", i), int'(mem_req.q_valid), int'(tbl[i].e_qv));
      if (tbl[i].e_qv) chk($sformatf("tbl%0d_q_addr", i), int'(mem_req.q.addr), int'(tbl[i].e_qa));
      chk($sformatf("tbl%0d_mode", i), int'(mode_o), int'(tbl[i].e_mode));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_lrv", i), int'(lrv), int'(tbl[i].e_lrv));
      chk($sformatf("tbl%0d_crv", i), int'(crv), int'(tbl[i].e_crv));
      if (i == 2) chkd("basic_rdata", ldata, {32{8'hA5}});
    end

    // outstanding limit, latency 3
    lat = 3; lrv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      set_in(c < 3, 1'b0, 10'h040 + 10'(c), 10'h000, 1'b0, 1'b1, 1'b0);
      step();
      if (lrv) lrv_cnt++;
      chk("os_inflight_le_max", int'(inflight_now() <= MAXO), 1);
      if (c == 3) chk("os_third_held", int'(mem_req.q_valid), 0);
      if (c == 4) chk("os_third_released", int'(mem_req.q_valid), 1);
    end
    chk("os_rvalid_count", lrv_cnt, 3);

    // deferred mode switch with an early compute request
    lrv_cnt = 0; sw_at = -1;
    for (int c = 0; c < 12; c++) begin
      set_in(c < 2, c == 2, 10'h050 + 10'(c), 10'h060, c >= 2, 1'b1, 1'b0);
      step();
      if (lrv) lrv_cnt++;
      if (c == 2) chk("ms_inactive_err", int'(err[1]), 1);
      if (mode_o && sw_at < 0) begin
        sw_at = c;
        chk("ms_loads_before_switch", lrv_cnt, 2);
      end
    end
    chk("ms_switch_at", sw_at, 6);
    set_in(1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1);
    step();

    // reset with two reads outstanding, then stale responses
    rv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      set_in(1'b0, c < 2, 10'h000, 10'h070 + 10'(c), c < 3, 1'b1, 1'b0);
      rst_n  = !(c == 3 || c == 4);
      inj_pv = (c == 6 || c == 7);
      step();
      if (c >= 3) begin
        if (lrv || crv) rv_cnt++;
        chk("rst_busy", int'(busy), 0);
      end
    end
    chk("rst_no_rvalid", rv_cnt, 0);
    chk("rst_mode", int'(mode_o), 0);
    inj_pv = 1'b0;

    // random traffic, latency 2
    lat = 2; rmode = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 5) rmode = !rmode;
      set_in($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35,
             10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
             rmode, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 8);
      step();
    end
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 1'b0, 10'h000, 10'h000, rmode, 1'b1, 1'b0);
      step();
    end
    chk("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
